// File: rtl/piezo_seq_if.sv
// Bundle of alarm request inputs and piezo drive/status outputs for piezo_seq.
// The slave side is the sequencer; the master side is the control logic or bench.
interface piezo_seq_if;
    logic       en_steer;
    logic       ovr_spd;
    logic       batt_low;
    logic       mute;
    logic       piezo;
    logic       piezo_n;
    logic       busy;
    logic [1:0] cur_src;
    logic [2:0] note_idx;

    modport slave (
        input  en_steer,
        input  ovr_spd,
        input  batt_low,
        input  mute,
        output piezo,
        output piezo_n,
        output busy,
        output cur_src,
        output note_idx
    );

    modport master (
        output en_steer,
        output ovr_spd,
        output batt_low,
        output mute,
        input  piezo,
        input  piezo_n,
        input  busy,
        input  cur_src,
        input  note_idx
    );
endinterface

// File: rtl/piezo_seq.sv
// Priority-arbitrated piezo alarm sequencer: plays a per-source note pattern on a
// differential pin pair, with mute, status outputs and a time-compressed sim mode.
module piezo_seq #(
    parameter int unsigned CLK_HZ     = 50000000,
    parameter bit          FAST_SIM   = 1'b0,
    parameter int unsigned FAST_SHIFT = 12,
    parameter int unsigned REPEAT_CYC = 150000000
) (
    input  logic        clk,
    input  logic        rst_n,
    piezo_seq_if.slave  pz_if
);

    localparam int unsigned CW = ($clog2(REPEAT_CYC) > 25) ? $clog2(REPEAT_CYC) : 25;

    function automatic int unsigned scale(input int unsigned v);
        int unsigned s;
        if (FAST_SIM) begin
            s = v >> FAST_SHIFT;
            if (s == 32'd0) begin
                s = 32'd1;
            end else begin
                s = s;
            end
        end else begin
            s = v;
        end
        return s;
    endfunction

    localparam logic [CW-1:0] ONE    = CW'(32'd1);
    localparam logic [CW-1:0] HP_G6  = CW'(scale(CLK_HZ / (32'd2 * 32'd1568)));
    localparam logic [CW-1:0] HP_C7  = CW'(scale(CLK_HZ / (32'd2 * 32'd2093)));
    localparam logic [CW-1:0] HP_E7  = CW'(scale(CLK_HZ / (32'd2 * 32'd2637)));
    localparam logic [CW-1:0] HP_G7  = CW'(scale(CLK_HZ / (32'd2 * 32'd3136)));
    localparam logic [CW-1:0] DUR_N  = CW'(scale(32'd8388608));
    localparam logic [CW-1:0] DUR_L  = CW'(scale(32'd12582912));
    localparam logic [CW-1:0] DUR_S  = CW'(scale(32'd4194304));
    localparam logic [CW-1:0] DUR_XL = CW'(scale(32'd16777216));
    localparam logic [CW-1:0] REP_M1 = CW'(scale(REPEAT_CYC) - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_GAP  = 2'd2
    } state_e;

    // Source 2 walks the fanfare backwards; the others use the position directly.
    function automatic logic [2:0] note_of(input logic [1:0] src, input logic [2:0] pos);
        logic [2:0] n;
        case (src)
            2'd2:    n = 3'd5 - pos;
            default: n = pos;
        endcase
        return n;
    endfunction

    function automatic logic [CW-1:0] hp_of(input logic [2:0] note);
        logic [CW-1:0] h;
        case (note)
            3'd0:       h = HP_G6;
            3'd1:       h = HP_C7;
            3'd2, 3'd4: h = HP_E7;
            3'd3, 3'd5: h = HP_G7;
            default:    h = HP_G6;
        endcase
        return h;
    endfunction

    function automatic logic [CW-1:0] dur_of(input logic [2:0] note);
        logic [CW-1:0] d;
        case (note)
            3'd3:    d = DUR_L;
            3'd4:    d = DUR_S;
            3'd5:    d = DUR_XL;
            default: d = DUR_N;
        endcase
        return d;
    endfunction

    state_e        state_q, state_d;
    logic [1:0]    src_q, src_d;
    logic [2:0]    pos_q, pos_d;
    logic [CW-1:0] dur_q, dur_d;
    logic [CW-1:0] hp_q, hp_d;
    logic [CW-1:0] rep_q, rep_d;
    logic          pin_q, pin_d;
    logic [1:0]    sel_s;
    logic [2:0]    note_s;
    logic          start_s;
    logic          idle_s;
    logic          sound_s;

    logic          piezo_q;
    logic          piezo_n_q;
    logic          busy_q;
    logic [1:0]    cur_src_q;
    logic [2:0]    note_idx_q;

    // Fixed-priority request selection.
    always_comb begin
        sel_s = 2'd0;
        if (pz_if.ovr_spd) begin
            sel_s = 2'd3;
        end else if (pz_if.batt_low) begin
            sel_s = 2'd2;
        end else if (pz_if.en_steer) begin
            sel_s = 2'd1;
        end else begin
            sel_s = 2'd0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= 2'd0;
            pos_q   <= 3'd0;
            dur_q   <= '0;
            hp_q    <= '0;
            rep_q   <= '0;
            pin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            pos_q   <= pos_d;
            dur_q   <= dur_d;
            hp_q    <= hp_d;
            rep_q   <= rep_d;
            pin_q   <= pin_d;
        end
    end

    // Next-state logic: arbitration, note stepping, tone toggling and repeat timing.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        pos_d   = pos_q;
        dur_d   = dur_q;
        hp_d    = hp_q;
        rep_d   = rep_q;
        pin_d   = pin_q;
        start_s = 1'b0;
        idle_s  = 1'b0;
        note_s  = note_of(src_q, pos_q);

        case (state_q)
            S_IDLE: begin
                if (sel_s != 2'd0) begin
                    start_s = 1'b1;
                end else begin
                    idle_s = 1'b1;
                end
            end
            S_PLAY: begin
                if (sel_s == 2'd0) begin
                    idle_s = 1'b1;
                end else if (sel_s != src_q) begin
                    start_s = 1'b1;
                end else begin
                    // The looping source never enters GAP, so its repeat count stays parked.
                    if ((src_q != 2'd3) && (rep_q != REP_M1)) begin
                        rep_d = rep_q + ONE;
                    end else begin
                        rep_d = rep_q;
                    end
                    if (dur_q == dur_of(note_s) - ONE) begin
                        dur_d = '0;
                        hp_d  = '0;
                        pin_d = 1'b1;
                        if (src_q == 2'd3) begin
                            pos_d = (pos_q == 3'd2) ? 3'd0 : pos_q + 3'd1;
                        end else if (pos_q == 3'd5) begin
                            state_d = S_GAP;
                            pos_d   = 3'd0;
                            pin_d   = 1'b0;
                        end else begin
                            pos_d = pos_q + 3'd1;
                        end
                    end else begin
                        dur_d = dur_q + ONE;
                        if (hp_q == hp_of(note_s) - ONE) begin
                            hp_d  = '0;
                            pin_d = ~pin_q;
                        end else begin
                            hp_d  = hp_q + ONE;
                            pin_d = pin_q;
                        end
                    end
                end
            end
            S_GAP: begin
                if (sel_s == 2'd0) begin
                    idle_s = 1'b1;
                end else if ((sel_s != src_q) || (rep_q == REP_M1)) begin
                    start_s = 1'b1;
                end else begin
                    rep_d = rep_q + ONE;
                end
            end
            default: begin
                idle_s = 1'b1;
            end
        endcase

        if (idle_s) begin
            state_d = S_IDLE;
            src_d   = 2'd0;
            pos_d   = 3'd0;
            dur_d   = '0;
            hp_d    = '0;
            rep_d   = '0;
            pin_d   = 1'b0;
        end else if (start_s) begin
            state_d = S_PLAY;
            src_d   = sel_s;
            pos_d   = 3'd0;
            dur_d   = '0;
            hp_d    = '0;
            rep_d   = '0;
            pin_d   = 1'b1;
        end else begin
            state_d = state_d;
        end
    end

    // Pins are driven only while a tone is sounding and not muted.
    always_comb begin
        sound_s = (state_d == S_PLAY) && !pz_if.mute;
    end

    // Registered pin and status outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            piezo_q    <= 1'b0;
            piezo_n_q  <= 1'b0;
            busy_q     <= 1'b0;
            cur_src_q  <= 2'd0;
            note_idx_q <= 3'd0;
        end else begin
            piezo_q    <= sound_s & pin_d;
            piezo_n_q  <= sound_s & ~pin_d;
            busy_q     <= (state_d != S_IDLE);
            cur_src_q  <= src_d;
            note_idx_q <= (state_d == S_PLAY) ? note_of(src_d, pos_d) : 3'd0;
        end
    end

    assign pz_if.piezo    = piezo_q;
    assign pz_if.piezo_n  = piezo_n_q;
    assign pz_if.busy     = busy_q;
    assign pz_if.cur_src  = cur_src_q;
    assign pz_if.note_idx = note_idx_q;

endmodule

// File: doc/piezo_seq.md
Name: piezo_seq

Overview:
- Parametrised successor to the single-pattern piezo driver.
- Arbitrates three alarm requests by fixed priority: ovr_spd > batt_low > en_steer.
- Plays a per-source note pattern (forward fanfare, reversed fanfare, or continuous short loop) on a differential piezo pair, with mute, status outputs and a simulation time-compression mode.
- Sits between the Segway control logic (steer enable, over-speed, battery monitor) and the board piezo pins.

Parameters:
- CLK_HZ, 50000000: clock frequency; half-period counts are floor(CLK_HZ/(2*f_note)).
- FAST_SIM, 0: when 1, every half-period, note duration and repeat count is right-shifted by FAST_SHIFT, with a minimum of 1.
- FAST_SHIFT, 12: shift amount used when FAST_SIM=1.
- REPEAT_CYC, 150000000: cycles from first-note start to pattern restart, for the fanfare modes.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- en_steer  in  1  request: forward fanfare, repeating.
- ovr_spd  in  1  request: continuous loop of notes 0-2.
- batt_low  in  1  request: reversed fanfare, repeating.
- mute  in  1  forces both pins low; sequencing continues.
- piezo  out  1  piezo drive, true side.
- piezo_n  out  1  piezo drive, complement side.
- busy  out  1  high in PLAY or GAP.
- cur_src  out  2  active source: 0 none, 1 en_steer, 2 batt_low, 3 ovr_spd.
- note_idx  out  3  index of the note currently sounding (0-5).

Behaviour:
- Note table (half-period @50MHz / duration cycles):
  - 0: G6, 15943 / 2^23
  - 1: C7, 11944 / 2^23
  - 2: E7, 9480 / 2^23
  - 3: G7, 7971 / 2^23+2^22
  - 4: E7, 9480 / 2^22
  - 5: G7, 7971 / 2^24
- Patterns:
  - src1: notes 0..5, then GAP until REPEAT_CYC elapsed since start, then restart.
  - src2: notes 5..0, same GAP and repeat rule.
  - src3: notes 0,1,2,0,1,2,... with no GAP.
- Requests are sampled every cycle. The selected source is the highest-priority asserted request.
- States:
  - IDLE: outputs quiet.
  - PLAY: tone running.
  - GAP: silent, repeat counter running.
- Transitions:
  - IDLE -> PLAY on the cycle after any request is seen high.
  - PLAY -> GAP after the last note of src1/src2.
  - GAP -> PLAY when the repeat counter reaches REPEAT_CYC-1.
  - Any state -> IDLE on the cycle after the selected source's request is seen low while no other request is high.
- Preemption: if the selected source changes (higher request rises, or active request drops while a lower one is high), the next cycle begins the new source's first note with all counters cleared.
- Note start: piezo=1, piezo_n=0.
  - Both pins toggle when the half-period counter reaches HP-1; the counter then clears.
  - A note lasts exactly DUR cycles; the next note starts with a fresh half-period count and piezo=1.
- Quiet (IDLE, GAP, or mute=1): piezo=0, piezo_n=0, so no DC is ever driven across the element.
- Playing: piezo_n = ~piezo at all times.
- Outputs:
  - busy = 1 in PLAY and GAP.
  - cur_src is held through GAP.
  - note_idx reflects the sounding note; it is 0 in IDLE and GAP.
- Reset: state IDLE, all counters 0, piezo=0, piezo_n=0, busy=0, cur_src=0, note_idx=0. Reset mid-note aborts immediately.
- Counter widths: sized for the largest unshifted value (REPEAT_CYC needs 28 bits). No wrap-around is permitted.

Test Plan:
- FAST_SIM=1 values: half-periods 3, 2, 2, 1; durations 2048 / 3072 / 1024 / 4096; repeat 36621.
- Reset with all requests high -> piezo=piezo_n=0, busy=0 throughout reset. First toggle of piezo occurs 3 cycles after PLAY entry, with piezo_n complementary.
- en_steer only -> note_idx steps 0..5 at cycle offsets 0, 2048, 4096, 6144, 9216, 10240. Pins are silent from 14336 to 36620. Note 0 restarts at 36621.
- batt_low only -> note_idx sequence 5, 4, 3, 2, 1, 0 with durations 4096, 1024, 3072, 2048, 2048, 2048; cur_src=2.
- en_steer playing, ovr_spd raised at offset 3000 -> next cycle cur_src=3, note_idx=0, piezo=1. Drop ovr_spd -> next cycle en_steer restarts at note 0.
- ovr_spd held for 20000 cycles -> notes loop 0, 1, 2 every 6144 cycles with busy never low. mute pulse of 100 cycles -> both pins 0, note timing unchanged.
- rst_n low for 1 cycle mid-note -> all outputs at reset values next cycle. If a request is still high, PLAY re-enters on the following cycle at note 0.
